// File: rtl/dec_lut_pkg.sv
// Shared types and constants for the DEC_LUT decoder scheduler slice.
package dec_lut_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } sched_state_t;

   localparam int DEF_W_BITS = 30;
   localparam int DEF_N_BITS = 17;
   localparam logic [16:0] EXP_N = 17'd65535;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dec_lut_sched_if.sv
// Request/response bus between requesters and the decoder scheduler.
interface dec_lut_sched_if
   import dec_lut_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2,
   parameter int W_BITS  = DEF_W_BITS,
   parameter int N_BITS  = DEF_N_BITS
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*W_BITS-1:0] req_w;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      resp_valid;
   logic                      resp_ready;
   logic [IDW-1:0]            resp_id;
   logic [N_BITS-1:0]         resp_n;
   logic                      resp_err;

   modport master (
      output req_valid, req_w, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_n, resp_err
   );

   modport slave (
      input  req_valid, req_w, resp_ready,
      output req_ready, resp_valid, resp_id, resp_n, resp_err
   );
endinterface

// File: rtl/dec_lut_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     idx,
   output logic               any
);

   logic [IDW:0] pos;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pos = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // ptr < NUM_REQ, so one conditional subtract is enough to wrap
         pos = {1'b0, ptr} + (IDW+1)'(k);
         if (pos >= (IDW+1)'(NUM_REQ)) pos = pos - (IDW+1)'(NUM_REQ);
         if (!any && req[pos[IDW-1:0]]) begin
            any                 = 1'b1;
            gnt[pos[IDW-1:0]]   = 1'b1;
            idx                 = pos[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/dec_lut_sched.sv
// Round-robin scheduler sharing one DEC_LUT decoder among NUM_REQ requesters,
// with a settle mask for stale found and a timeout for undecodable words.
module dec_lut_sched
   import dec_lut_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2,
   parameter int W_BITS  = DEF_W_BITS,
   parameter int N_BITS  = DEF_N_BITS,
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   dec_lut_sched_if.slave    bus,
   output logic [W_BITS-1:0] dec_W,
   input  logic              dec_found,
   input  logic [N_BITS-1:0] dec_N,
   output logic              busy
);

   localparam int CNT_W = clog2(TIMEOUT + 1);

   sched_state_t       state_q, state_d;
   logic [IDW-1:0]     rr_ptr;
   logic [CNT_W-1:0]   wait_cnt;
   logic [NUM_REQ-1:0] gnt;
   logic [IDW-1:0]     gnt_idx;
   logic               gnt_any;
   logic               do_grant, do_found, do_tmo, do_hs;
   logic               settled;

   logic               resp_valid_q, resp_err_q;
   logic [IDW-1:0]     resp_id_q;
   logic [N_BITS-1:0]  resp_n_q;

   logic [W_BITS-1:0]  slot [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
      assign slot[i] = bus.req_w[i*W_BITS +: W_BITS];
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
      .req (bus.req_valid),
      .ptr (rr_ptr),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   // found from the decoder is only meaningful once the new word has settled
   assign settled = (wait_cnt >= CNT_W'(SETTLE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.req_ready = '0;
      do_grant      = 1'b0;
      do_found      = 1'b0;
      do_tmo        = 1'b0;
      do_hs         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.req_ready = gnt;
            if (gnt_any) begin
               do_grant = 1'b1;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (settled && dec_found) begin
               do_found = 1'b1;
               state_d  = ST_RESP;
            end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
               do_tmo  = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               do_hs   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= '0;
         wait_cnt     <= '0;
         dec_W        <= '0;
         resp_id_q    <= '0;
         resp_n_q     <= '0;
         resp_err_q   <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         if (do_grant) begin
            dec_W     <= slot[gnt_idx];
            resp_id_q <= gnt_idx;
            rr_ptr    <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            wait_cnt  <= '0;
         end else if (state_q == ST_WAIT && wait_cnt != CNT_W'(TIMEOUT)) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (do_found) begin
            resp_n_q     <= dec_N;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
         end
         if (do_tmo) begin
            resp_n_q     <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
         end
         if (do_hs) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
         end
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_n     = resp_n_q;
   assign bus.resp_err   = resp_err_q;
   assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dec_lut_sched.sv
// Randomized self-checking bench for dec_lut_sched; the bench plays the decoder.
module tb_dec_lut_sched;
   import dec_lut_pkg::*;

   localparam int NR  = 4;
   localparam int IW  = 2;
   localparam int WB  = 30;
   localparam int NB  = 17;
   localparam int SET = 2;
   localparam int TMO = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [WB-1:0] dec_W;
   logic          dec_found;
   logic [NB-1:0] dec_N;
   logic          busy;

   int n_chk  = 0;
   int n_fail = 0;
   int ptr_m  = 0;

   dec_lut_sched_if #(.NUM_REQ(NR), .IDW(IW), .W_BITS(WB), .N_BITS(NB)) bus ();

   dec_lut_sched #(
      .NUM_REQ(NR), .IDW(IW), .W_BITS(WB), .N_BITS(NB), .SETTLE(SET), .TIMEOUT(TMO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dec_W     (dec_W),
      .dec_found (dec_found),
      .dec_N     (dec_N),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Round-robin rule: first valid index scanning p, p+1, ... modulo NR.
   function automatic int pick(input logic [NR-1:0] v, input int p);
      logic [NR-1:0] t;
      for (int k = 0; k < NR; k++) begin
         t = v >> ((p + k) % NR);
         if (t[0]) return (p + k) % NR;
      end
      return -1;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'(0));
      check({tag, "_resp_id"},    64'(bus.resp_id),    64'(0));
      check({tag, "_resp_n"},     64'(bus.resp_n),     64'(0));
      check({tag, "_resp_err"},   64'(bus.resp_err),   64'(0));
      check({tag, "_req_ready"},  64'(bus.req_ready),  64'(0));
      check({tag, "_busy"},       64'(busy),           64'(0));
      check({tag, "_dec_W"},      64'(dec_W),          64'(0));
   endtask

   // One transaction: found rises f cycles after grant (f > TMO means never),
   // stale keeps found high throughout, bp cycles of response backpressure.
   task automatic run_txn(input logic [NR-1:0] v, input int f, input bit stale,
                          input int bp, input bit fixed_n);
      int              g, c_resp, fe;
      bit              err;
      logic [NB-1:0]   n_drv, exp_n;
      logic [WB-1:0]   ew;
      logic [NR-1:0]   oh;
      logic [127:0]    r128;
      logic [NR*WB-1:0] wflat, tmp;

      r128  = {$urandom(), $urandom(), $urandom(), $urandom()};
      wflat = r128[NR*WB-1:0];
      bus.req_w     = wflat;
      bus.req_valid = v;
      dec_found     = stale;
      g  = pick(v, ptr_m);
      oh = '0;
      if (g >= 0) oh = NR'(1) << g;
      #1;
      check("req_ready_idle", 64'(bus.req_ready), 64'(oh));
      check("busy_idle", 64'(busy), 64'(0));
      step();
      tmp = wflat >> (g * WB);
      ew  = tmp[WB-1:0];
      bus.req_valid = NR'($urandom);
      #1;
      check("dec_W_grant", 64'(dec_W), 64'(ew));
      check("busy_wait", 64'(busy), 64'(1));
      check("resp_id_grant", 64'(bus.resp_id), 64'(g));
      check("req_ready_wait", 64'(bus.req_ready), 64'(0));

      fe = stale ? 0 : f;
      if (fe <= TMO) begin
         c_resp = ((fe > SET) ? fe : SET) + 1;
         err    = 1'b0;
      end else begin
         c_resp = TMO + 1;
         err    = 1'b1;
      end
      n_drv = '0;
      for (int c = 0; c < c_resp; c++) begin
         dec_found = stale || (c >= fe);
         n_drv     = fixed_n ? EXP_N : NB'($urandom);
         dec_N     = n_drv;
         step();
         check("resp_valid_timing", 64'(bus.resp_valid), 64'(c + 1 == c_resp));
      end
      exp_n = err ? '0 : n_drv;
      check("resp_id", 64'(bus.resp_id), 64'(g));
      check("resp_n", 64'(bus.resp_n), 64'(exp_n));
      check("resp_err", 64'(bus.resp_err), 64'(err));
      check("dec_W_held", 64'(dec_W), 64'(ew));

      for (int b = 0; b < bp; b++) begin
         dec_N         = NB'($urandom);
         dec_found     = 1'($urandom);
         bus.req_valid = NR'($urandom);
         #1;
         check("req_ready_resp", 64'(bus.req_ready), 64'(0));
         step();
         check("bp_resp_valid", 64'(bus.resp_valid), 64'(1));
         check("bp_resp_id", 64'(bus.resp_id), 64'(g));
         check("bp_resp_n", 64'(bus.resp_n), 64'(exp_n));
         check("bp_resp_err", 64'(bus.resp_err), 64'(err));
         check("bp_dec_W", 64'(dec_W), 64'(ew));
      end

      bus.resp_ready = 1'b1;
      bus.req_valid  = NR'($urandom);
      step();
      bus.resp_ready = 1'b0;
      check("hs_resp_valid", 64'(bus.resp_valid), 64'(0));
      check("hs_resp_err", 64'(bus.resp_err), 64'(0));
      check("hs_no_grant", 64'(busy), 64'(0));
      check("hs_dec_W_kept", 64'(dec_W), 64'(ew));
      ptr_m = (g + 1) % NR;
      bus.req_valid = '0;
   endtask

   // All requesters valid, consumer always ready, found always high.
   task automatic run_stream();
      int exp_id, last, seen;
      logic [NB-1:0] n_fix;
      n_fix          = NB'($urandom);
      dec_N          = n_fix;
      dec_found      = 1'b1;
      bus.resp_ready = 1'b1;
      bus.req_valid  = '1;
      exp_id = ptr_m;
      last   = -1;
      seen   = 0;
      for (int cyc = 0; cyc < 60 && seen < 5; cyc++) begin
         step();
         if (bus.resp_valid) begin
            check("stream_id", 64'(bus.resp_id), 64'(exp_id));
            check("stream_n", 64'(bus.resp_n), 64'(n_fix));
            if (last >= 0) check("stream_spacing", 64'(cyc - last >= 5), 64'(1));
            last   = cyc;
            exp_id = (exp_id + 1) % NR;
            seen++;
            if (seen == 5) bus.req_valid = '0;
         end
      end
      check("stream_count", 64'(seen), 64'(5));
      step();
      bus.resp_ready = 1'b0;
      check("stream_idle", 64'(busy), 64'(0));
      ptr_m = exp_id;
   endtask

   initial begin
      int r, f, bp;
      bit stale;
      bus.req_valid  = '0;
      bus.req_w      = '0;
      bus.resp_ready = 1'b0;
      dec_found      = 1'b0;
      dec_N          = '0;
      rst_n          = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      run_stream();
      run_txn(NR'(1), 0, 1'b1, 0, 1'b1);
      run_txn('1, 1000, 1'b0, 10, 1'b0);
      run_txn('1, 0, 1'b1, 0, 1'b0);

      for (int it = 0; it < 30; it++) begin
         r     = $urandom_range(0, 9);
         stale = (r >= 1 && r <= 3);
         f     = (r == 0) ? 1000 : $urandom_range(0, 8);
         bp    = $urandom_range(0, 3);
         run_txn(NR'($urandom_range(1, 15)), f, stale, bp, 1'b0);
      end

      bus.req_valid = NR'(2);
      dec_found     = 1'b0;
      step();
      bus.req_valid = '0;
      step();
      check("pre_reset_busy", 64'(busy), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      step();
      check("reset_no_resp", 64'(bus.resp_valid), 64'(0));
      rst_n = 1'b1;
      ptr_m = 0;
      run_txn(NR'(4), 0, 1'b1, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dec_lut_sched.md
Name: dec_lut_sched

Overview:
- Round-robin scheduler that shares one DEC_LUT_Decoder16bits_clk instance among NUM_REQ requesters.
- Accepts a W codeword from one requester at a time and drives it onto the decoder's W input, holding it stable.
- Waits for a qualified `found`, captures N and returns it with the requester ID over a valid/ready response port.
- Has a timeout so a non-decodable W cannot hang the shared decoder.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must equal clog2(NUM_REQ).
- W_BITS, 30, codeword width, matches decoder W.
- N_BITS, 17, decoded value width, matches decoder N.
- SETTLE, 2, cycles after a new dec_W before dec_found is trusted (masks a stale `found` from the previous word).
- TIMEOUT, 64, maximum WAIT cycles before an error response; TIMEOUT > SETTLE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_w  in  NUM_REQ*W_BITS  flattened codewords; slice i = req_w[i*W_BITS +: W_BITS].
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
- dec_W  out  W_BITS  to decoder W.
- dec_found  in  1  from decoder found.
- dec_N  in  N_BITS  from decoder N.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  IDW  index of the served requester.
- resp_n  out  N_BITS  decoded N; 0 when resp_err.
- resp_err  out  1  timeout, no found.
- busy  out  1  high in WAIT or RESP.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, dec_W=0, wait_cnt=0. All outputs are 0: resp_valid, resp_id, resp_n, resp_err, req_ready, busy. Reset mid-operation abandons the transaction; no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational. It is one-hot on the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ; otherwise all 0.
  - On a grant edge: dec_W<=req_w slice g, resp_id<=g, rr_ptr<=(g+1) mod NUM_REQ, wait_cnt<=0, state->WAIT.
- WAIT:
  - req_ready=0. dec_W is held constant.
  - wait_cnt increments each cycle and saturates at TIMEOUT.
  - dec_found is ignored while wait_cnt<SETTLE.
  - If wait_cnt>=SETTLE and dec_found=1: resp_n<=dec_N, resp_err<=0, resp_valid<=1, state->RESP.
  - Else if wait_cnt==TIMEOUT: resp_n<=0, resp_err<=1, resp_valid<=1, state->RESP.
  - found has priority over timeout in the same cycle.
- RESP:
  - resp_valid, resp_id, resp_n and resp_err are held stable until resp_ready=1.
  - On the handshake edge: resp_valid<=0, resp_err<=0, state->IDLE.
  - dec_W keeps its last value until the next grant.
  - No new grant happens in the handshake cycle.
- Latency: grant at edge t. With SETTLE=2 and found already high, resp_valid rises after edge t+3. Minimum request-to-request spacing is 5 cycles when resp_ready is held high.
- Fairness:
  - Requests that drop before grant are ignored.
  - With all NUM_REQ requesters valid, the grant order is 0,1,2,3,0,...
  - rr_ptr advances only on grant.
- Width rules: resp_id is g truncated to IDW; wait_cnt is clog2(TIMEOUT+1) bits.

Decomposition:
- Package dec_lut_pkg holds:
  - FSM state enum.
  - Default W_BITS=30, N_BITS=17, and the expected-N constant 17'd65535 used by benches.
  - clog2 helper function.
- Sub-module rr_arbiter (NUM_REQ) provides combinational one-hot grant from the request vector and pointer, plus the encoded index. The pointer register stays in dec_lut_sched.
- The decoder is instantiated outside, at top level.

Test Plan:
- Single request: req_valid=4'b0001, W from test_vectors.txt, decoder returns N=65535 -> resp_valid with resp_id=0, resp_n=65535, resp_err=0, 3 cycles after grant.
- All four valid continuously, resp_ready=1 -> grants 0,1,2,3,0; resp_id sequence matches; each response spaced ≥5 cycles.
- Stale found: dec_found held 1 across transactions -> no response earlier than SETTLE cycles after the new dec_W; resp_n equals dec_N at the sample cycle.
- Timeout: dec_found stuck 0 -> after 64 WAIT cycles resp_err=1, resp_n=0; the next requester is granted after the handshake.
- Backpressure: resp_ready=0 for 10 cycles -> resp_valid, resp_id and resp_n stable; no req_ready asserted; dec_W unchanged.
- Async reset asserted in WAIT -> all outputs 0 immediately; after release, req_valid=4'b0100 is granted first (rr_ptr=0 search finds index 2).
